// File: rtl/receiver_packet_capture.sv
// Receive-side packet capture: deserializes a 71-bit packet (address, data, CRC) and forwards good packets on valid/ready.
// Latency: out_valid rises on the edge after the crc_done/crc_good cycle; capture spans the start cycle plus PKT_LEN-1 cycles.
// Backpressure: a single output register; a good packet arriving while it is occupied is dropped and flags sticky overflow.
// Optional build macro RX_ADDR_FILTER_EN adds addr_lo/addr_hi and silently drops good packets outside that inclusive window.
module receiver_packet_capture #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 36,
    parameter int CRC_W        = 16,
    parameter int CRC_WAIT_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              serial_data_in,
    input  logic              crc_done,
    input  logic              crc_good,
`ifdef RX_ADDR_FILTER_EN
    input  logic [ADDR_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] addr_hi,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              overflow,
    output logic [15:0]       good_count,
    output logic [15:0]       bad_count
);

    localparam int PKT_LEN = ADDR_W + DATA_W + CRC_W;
    localparam int CNT_W   = $clog2(PKT_LEN + 1);
    localparam int WAIT_W  = $clog2(CRC_WAIT_MAX + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(PKT_LEN - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(CRC_WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PKT_LEN-1:0]  sreg_q, sreg_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         good_cnt_q, good_cnt_d;
    logic [15:0]         bad_cnt_q, bad_cnt_d;

    logic                good_inc;
    logic                bad_inc;
    logic                capture;
    logic                out_free;
    logic                addr_ok;
    logic [ADDR_W-1:0]   pkt_addr;
    logic [DATA_W-1:0]   pkt_data;

    // Fields of a completed packet: address on top, data next, CRC in the low bits (not kept).
    assign pkt_addr = sreg_q[PKT_LEN-1 -: ADDR_W];
    assign pkt_data = sreg_q[CRC_W +: DATA_W];

    // The output register can accept a new packet if empty or being popped this very cycle.
    assign out_free = !out_valid_q || out_ready;

`ifdef RX_ADDR_FILTER_EN
    assign addr_ok = (pkt_addr >= addr_lo) && (pkt_addr <= addr_hi);
`else
    assign addr_ok = 1'b1;
`endif

    // Next-state logic: capture FSM, verdict handling, output register and counters.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        overflow_d  = overflow_q;
        good_inc    = 1'b0;
        bad_inc     = 1'b0;
        capture     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                end
            end

            S_SHIFT: begin
                // start is deliberately ignored while a packet is being shifted in.
                sreg_d    = {sreg_q[PKT_LEN-2:0], serial_data_in};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end

            S_WAIT: begin
                if (crc_done) begin
                    // A verdict always wins over a coincident start; the new capture follows below.
                    if (crc_good) begin
                        if (!addr_ok) begin
                            // Out-of-window address: dropped without any trace.
                        end else if (out_free) begin
                            out_valid_d = 1'b1;
                            out_addr_d  = pkt_addr;
                            out_data_d  = pkt_data;
                            good_inc    = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else begin
                        bad_inc = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (start || (wait_cnt_q == LAST_WAIT)) begin
                    // Preempted by a new packet or the checker never answered: the pending packet is bad.
                    bad_inc = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end

                if (start) begin
                    capture = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new capture starts with the first bit in the LSB and one bit counted.
        if (capture) begin
            sreg_d    = {{(PKT_LEN-1){1'b0}}, serial_data_in};
            bit_cnt_d = CNT_W'(1);
            state_d   = S_SHIFT;
        end

        // Counters saturate at all-ones instead of wrapping.
        good_cnt_d = (good_inc && (good_cnt_q != 16'hFFFF)) ? good_cnt_q + 16'd1 : good_cnt_q;
        bad_cnt_d  = (bad_inc  && (bad_cnt_q  != 16'hFFFF)) ? bad_cnt_q  + 16'd1 : bad_cnt_q;
    end

    // State registers; reset discards any partial capture and clears all outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q != S_IDLE);
    assign overflow   = overflow_q;
    assign good_count = good_cnt_q;
    assign bad_count  = bad_cnt_q;

endmodule

// File: doc/receiver_packet_capture.md
Name: receiver_packet_capture

Overview:
- Sits beside the receiver CRC checker on the optical receive path and taps the same serial_data_in / start stream.
- Deserializes each 71-bit packet, sent MSB first: 19-bit address, then 36-bit data, then 16-bit CRC.
- Waits for the checker's done/crc_good verdict. A good packet is presented downstream on a valid/ready interface; a bad packet is discarded and counted.

Parameters:
- ADDR_W, 19, address field width
- DATA_W, 36, data field width
- CRC_W, 16, CRC field width; packet length PKT_LEN = ADDR_W+DATA_W+CRC_W = 71
- CRC_WAIT_MAX, 4, cycles allowed in WAIT_CRC for the crc_done pulse before a timeout

Ports:
- clock  input  1  system clock, all logic on posedge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  packet start strobe; the first packet bit is valid on serial_data_in in the same cycle
- serial_data_in  input  1  serial packet bit, one per clock
- crc_done  input  1  one-cycle verdict pulse from the CRC checker
- crc_good  input  1  CRC verdict, qualified by crc_done
- out_valid  output  1  out_addr/out_data hold a good packet
- out_ready  input  1  downstream accepts when out_valid && out_ready
- out_addr  output  ADDR_W  captured address
- out_data  output  DATA_W  captured data
- busy  output  1  high in SHIFT or WAIT_CRC
- overflow  output  1  sticky; a good packet was dropped because the output was occupied
- good_count  output  16  saturating count of good packets delivered to the output register
- bad_count  output  16  saturating count of rejected packets

Behaviour:
- Reset values: out_valid=0, out_addr=0, out_data=0, busy=0, overflow=0, good_count=0, bad_count=0, FSM=IDLE, shift register=0, bit counter=0.
- FSM states: IDLE, SHIFT, WAIT_CRC.
- IDLE:
  - start=1: sample serial_data_in into the shift register LSB, set bit counter=1, go to SHIFT.
  - start=0: hold.
- SHIFT:
  - Each cycle, shift the register left and insert serial_data_in; increment the bit counter.
  - The cycle that samples bit PKT_LEN (counter == PKT_LEN-1 on entry) goes to WAIT_CRC with the wait counter = 0.
  - start is ignored in SHIFT.
  - Capture therefore covers the start cycle plus 70 following cycles.
- Field split when the packet is complete:
  - address = shift register [70:52]
  - data = [51:16]
  - CRC bits [15:0] are discarded.
- WAIT_CRC:
  - crc_done && crc_good, output free: load out_addr/out_data, set out_valid, increment good_count, go to IDLE.
  - crc_done && crc_good, output occupied: drop the packet, set overflow, go to IDLE. good_count is not incremented.
  - crc_done && !crc_good: increment bad_count, go to IDLE.
  - No crc_done within CRC_WAIT_MAX cycles: timeout; increment bad_count, go to IDLE.
  - start=1 with no crc_done in the same cycle: count the pending packet as bad, then begin a new capture exactly as from IDLE (go to SHIFT).
  - crc_done and start in the same cycle: crc_done is resolved first, then the new capture begins.
- "Output free" means out_valid==0, or out_valid && out_ready in the same cycle, so a simultaneous pop and load is allowed.
- Output handshake:
  - out_valid stays high and out_addr/out_data stay stable until a cycle with out_ready=1.
  - On that cycle out_valid clears unless a new good packet loads simultaneously.
- Latency: out_valid rises on the clock edge after the crc_done/crc_good cycle.
- Counters: saturate at 16'hFFFF with no wrap. overflow clears only on reset.
- Reset mid-packet: the partial capture is discarded and no counter increments.

Optional Feature:
- Macro: RX_ADDR_FILTER_EN.
- When defined:
  - Adds input ports addr_lo and addr_hi, each ADDR_W wide.
  - A good packet whose address lies outside [addr_lo, addr_hi] inclusive is dropped silently.
  - A dropped packet does not set out_valid, does not affect overflow, and increments neither counter.
- When undefined: the ports are absent and every good packet is delivered.

Test Plan:
- Single good packet, address 19'h1A2B3, data 36'h0_DEAD_BEEF plus CRC; crc_done/crc_good=1 one cycle after the last bit -> out_valid next edge, out_addr=19'h1A2B3, out_data=36'h0DEADBEEF, good_count=1.
- Same packet with crc_good=0 -> out_valid stays 0, bad_count=1, FSM back to IDLE, busy=0.
- Two good packets, out_ready held 0 -> first held stable, second dropped, overflow=1, good_count=1. Then out_ready=1 for one cycle -> out_valid falls.
- crc_done never asserted -> bad_count=1 after CRC_WAIT_MAX cycles in WAIT_CRC. A start pulse mid-SHIFT is ignored and the capture completes normally.
- Reset asserted at bit 30 -> all outputs 0 immediately (async). The next full packet is captured correctly.
- RX_ADDR_FILTER_EN, addr_lo=19'h100, addr_hi=19'h1FF; good packets at 19'h150 and 19'h250 -> only 19'h150 delivered, good_count=1, bad_count=0.
